// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the single register-file write port; REGFILE_ARB_STATS_EN builds grant/XZR-drop counters
module regfile_write_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_reg,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]        WriteData,
  output logic [NREQ*16-1:0]       grant_count,
  output logic [15:0]              xzr_drop_count
);
  localparam int PW = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [PW:0] s;
  logic found, xfer, xzr;
  logic [ADDR_W-1:0] sel_reg, wr_q, wr_d;
  logic [DATA_W-1:0] sel_data, wd_q, wd_d;
  logic rw_q, rw_d;
  // first valid requester scanning from ptr with wraparound
  always_comb begin
    found = 1'b0;
    win = '0;
    s = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr_q} + (PW+1)'(k);
      if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
      if (!found && req_valid[s[PW-1:0]]) begin
        found = 1'b1;
        win = s[PW-1:0];
      end
    end
  end
  assign xfer      = found & ~stall & ~reset;
  assign req_ready = xfer ? NREQ'(1) << win : '0;
  assign sel_reg   = req_reg[win*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[win*DATA_W +: DATA_W];
  assign xzr       = sel_reg == XZR;
  assign ptr_d     = xfer ? (win == PW'(NREQ-1) ? '0 : win + 1'b1) : ptr_q;
  assign rw_d      = xfer & ~xzr;
  assign wr_d      = xfer ? sel_reg : wr_q;
  assign wd_d      = xfer ? sel_data : wd_q;
  // pointer and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      rw_q  <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      rw_q  <= rw_d;
      wr_q  <= wr_d;
      wd_q  <= wd_d;
    end
  end
  assign RegWrite      = rw_q;
  assign WriteRegister = wr_q;
  assign WriteData     = wd_q;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] gc_q [NREQ];
  logic [15:0] xc_q;
  // saturating per-requester grant counters and XZR drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) gc_q[i] <= '0;
      xc_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (xfer && win == PW'(i) && gc_q[i] != 16'hFFFF) gc_q[i] <= gc_q[i] + 16'd1;
      if (xfer && xzr && xc_q != 16'hFFFF) xc_q <= xc_q + 16'd1;
    end
  end
  // flatten counters onto the packed port
  always_comb begin
    for (int i = 0; i < NREQ; i++) grant_count[i*16 +: 16] = gc_q[i];
  end
  assign xzr_drop_count = xc_q;
`else
  assign grant_count    = '0;
  assign xzr_drop_count = '0;
`endif
endmodule
